// File: rtl/tag_directory.sv
// tag_directory: set-associative tag store with dirty bits, true-LRU victim selection and a clearing sweep
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   flush, busy            start a full invalidate sweep (IDLE only); high while sweeping
//   req_valid, req_ready   request handshake; ready only in IDLE without a pending flush
//   req_op/set/tag/way/dirty  operation (LOOKUP, WRITE, FILL, INVAL) and its operands
//   rsp_valid/hit/way/dirty   registered one-cycle response for the previous accepted request
//   victim_way/valid/dirty/tag  replacement candidate of the accepted request's set, pre-update
module tag_directory #(
  parameter int NUM_SETS = 128,
  parameter int WAYS = 4,
  parameter int TAG_BITS = 19,
  parameter int SET_BITS = $clog2(NUM_SETS),
  parameter int WAY_BITS = $clog2(WAYS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  output logic                busy,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [1:0]          req_op,
  input  logic [SET_BITS-1:0] req_set,
  input  logic [TAG_BITS-1:0] req_tag,
  input  logic [WAY_BITS-1:0] req_way,
  input  logic                req_dirty,
  output logic                rsp_valid,
  output logic                rsp_hit,
  output logic [WAY_BITS-1:0] rsp_way,
  output logic                rsp_dirty,
  output logic [WAY_BITS-1:0] victim_way,
  output logic                victim_valid,
  output logic                victim_dirty,
  output logic [TAG_BITS-1:0] victim_tag
);
  typedef enum logic {INIT, IDLE} state_t;
  state_t state, state_nxt;
  logic [SET_BITS-1:0] cnt;
  logic [TAG_BITS-1:0] tag_q [NUM_SETS][WAYS];
  logic [WAYS-1:0] valid_q [NUM_SETS];
  logic [WAYS-1:0] dirty_q [NUM_SETS];
  logic [WAY_BITS-1:0] age_q [NUM_SETS][WAYS];
  logic accept, hit, lw, touch, inv_found;
  logic [WAY_BITS-1:0] hit_way, inv_way, lru_way, vic_way, tw;
  logic [WAYS-1:0] set_v, set_d, v_nxt, d_nxt;
  logic [WAY_BITS-1:0] age_nxt [WAYS];

  assign busy = (state == INIT);
  assign req_ready = (state == IDLE) && !flush;
  assign accept = req_valid && req_ready;
  assign lw = !req_op[1];

  always_comb begin
    state_nxt = (state == INIT) ? ((cnt == SET_BITS'(NUM_SETS - 1)) ? IDLE : INIT) : (flush ? INIT : IDLE);
  end

  // Descending scans so the lowest matching / lowest invalid way wins.
  always_comb begin
    set_v = valid_q[req_set];
    set_d = dirty_q[req_set];
    hit = 1'b0;
    hit_way = '0;
    inv_found = 1'b0;
    inv_way = '0;
    lru_way = '0;
    for (int i = 0; i < WAYS; i++)
      if (age_q[req_set][i] == WAY_BITS'(WAYS - 1)) lru_way = WAY_BITS'(i);
    for (int i = WAYS - 1; i >= 0; i--) begin
      if (set_v[i] && tag_q[req_set][i] == req_tag) begin
        hit = 1'b1;
        hit_way = WAY_BITS'(i);
      end
      if (!set_v[i]) begin
        inv_found = 1'b1;
        inv_way = WAY_BITS'(i);
      end
    end
    vic_way = inv_found ? inv_way : lru_way;
    touch = lw ? hit : (req_op == 2'b10);
    tw = req_op[1] ? req_way : hit_way;
    v_nxt = set_v;
    d_nxt = set_d;
    if (req_op == 2'b01 && hit) d_nxt[hit_way] = 1'b1;
    if (req_op == 2'b10) begin
      v_nxt[req_way] = 1'b1;
      d_nxt[req_way] = req_dirty;
    end
    if (req_op == 2'b11) begin
      v_nxt[req_way] = 1'b0;
      d_nxt[req_way] = 1'b0;
    end
    // Touched way becomes MRU; ways younger than it age by one, keeping a permutation.
    for (int i = 0; i < WAYS; i++)
      age_nxt[i] = (WAY_BITS'(i) == tw) ? '0 : age_q[req_set][i] + WAY_BITS'(age_q[req_set][i] < age_q[req_set][tw]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= INIT;
      cnt <= '0;
      rsp_valid <= 1'b0;
      rsp_hit <= 1'b0;
      rsp_way <= '0;
      rsp_dirty <= 1'b0;
      victim_way <= '0;
      victim_valid <= 1'b0;
      victim_dirty <= 1'b0;
      victim_tag <= '0;
    end else begin
      state <= state_nxt;
      cnt <= (state == INIT) ? cnt + 1'b1 : '0;
      rsp_valid <= accept;
      if (accept) begin
        rsp_hit <= lw && hit;
        rsp_way <= hit_way;
        rsp_dirty <= lw && hit && set_d[hit_way];
        victim_way <= vic_way;
        victim_valid <= set_v[vic_way];
        victim_dirty <= set_d[vic_way];
        victim_tag <= tag_q[req_set][vic_way];
      end
    end
  end

  // Storage is not reset; the sweep initialises valid/dirty/age one set per cycle.
  always_ff @(posedge clk) begin
    if (state == INIT) begin
      valid_q[cnt] <= '0;
      dirty_q[cnt] <= '0;
      for (int i = 0; i < WAYS; i++) age_q[cnt][i] <= WAY_BITS'(i);
    end else if (accept) begin
      valid_q[req_set] <= v_nxt;
      dirty_q[req_set] <= d_nxt;
      if (req_op == 2'b10) tag_q[req_set][req_way] <= req_tag;
      if (touch)
        for (int i = 0; i < WAYS; i++) age_q[req_set][i] <= age_nxt[i];
    end
  end
endmodule

// File: tb/tb_tag_directory.sv
// tb_tag_directory: randomized check of tag_directory against a recency-list reference model
module tb_tag_directory;
  localparam int NS = 128;
  localparam int W = 4;
  logic clk = 0;
  logic rst_n = 0;
  logic flush = 0;
  logic busy, req_ready, rsp_valid, rsp_hit, rsp_dirty, victim_valid, victim_dirty;
  logic req_valid = 0;
  logic [1:0] req_op = '0;
  logic [6:0] req_set = '0;
  logic [18:0] req_tag = '0;
  logic [1:0] req_way = '0;
  logic req_dirty = 0;
  logic [1:0] rsp_way, victim_way;
  logic [18:0] victim_tag;
  int total = 0;
  int bad = 0;
  logic last_hit = 0;
  logic [18:0] m_tag [NS][W];
  bit m_v [NS][W];
  bit m_d [NS][W];
  int ord [NS][W];

  tag_directory dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .busy(busy),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_set(req_set),
    .req_tag(req_tag), .req_way(req_way), .req_dirty(req_dirty),
    .rsp_valid(rsp_valid), .rsp_hit(rsp_hit), .rsp_way(rsp_way), .rsp_dirty(rsp_dirty),
    .victim_way(victim_way), .victim_valid(victim_valid), .victim_dirty(victim_dirty),
    .victim_tag(victim_tag)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic void m_sweep();
    for (int s = 0; s < NS; s++)
      for (int w = 0; w < W; w++) begin
        m_v[s][w] = 0;
        m_d[s][w] = 0;
        ord[s][w] = w;
      end
  endfunction

  // ord[s] lists ways from most to least recently used.
  function automatic void m_touch(input int s, input int w);
    int p = 0;
    for (int k = 0; k < W; k++) if (ord[s][k] == w) p = k;
    for (int k = p; k > 0; k--) ord[s][k] = ord[s][k-1];
    ord[s][0] = w;
  endfunction

  task automatic check_reset_vals();
    chk("rst_busy", busy, 1);
    chk("rst_ready", req_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_hit", rsp_hit, 0);
    chk("rst_rsp_way", rsp_way, 0);
    chk("rst_rsp_dirty", rsp_dirty, 0);
    chk("rst_vic_way", victim_way, 0);
    chk("rst_vic_valid", victim_valid, 0);
    chk("rst_vic_dirty", victim_dirty, 0);
    chk("rst_vic_tag", victim_tag, 0);
  endtask

  task automatic wait_sweep(input int exp);
    int n = 0;
    bit rdy_seen = 0;
    while (busy && n < 1000) begin
      if (req_ready) rdy_seen = 1;
      @(posedge clk);
      #1;
      n++;
    end
    chk("sweep_len", n, exp);
    chk("ready_in_sweep", rdy_seen, 0);
    chk("ready_after_sweep", req_ready, 1);
    m_sweep();
  endtask

  task automatic op(input logic [1:0] o, input int s, input int t, input int w, input logic d);
    bit hit = 0;
    int hw = 0;
    int vic = -1;
    bit e_hit, e_dirty, e_vv, e_vd;
    logic [18:0] e_vt;
    req_valid = 1;
    req_op = o;
    req_set = 7'(s);
    req_tag = 19'(t);
    req_way = 2'(w);
    req_dirty = d;
    for (int k = 0; k < W; k++)
      if (!hit && m_v[s][k] && m_tag[s][k] == 19'(t)) begin
        hit = 1;
        hw = k;
      end
    for (int k = 0; k < W; k++) if (vic < 0 && !m_v[s][k]) vic = k;
    if (vic < 0) vic = ord[s][W-1];
    e_vv = m_v[s][vic];
    e_vd = m_d[s][vic];
    e_vt = m_tag[s][vic];
    e_hit = (o < 2) && hit;
    e_dirty = e_hit && m_d[s][hw];
    if (o == 0 && hit) m_touch(s, hw);
    if (o == 1 && hit) begin
      m_d[s][hw] = 1;
      m_touch(s, hw);
    end
    if (o == 2) begin
      m_tag[s][w] = 19'(t);
      m_v[s][w] = 1;
      m_d[s][w] = d;
      m_touch(s, w);
    end
    if (o == 3) begin
      m_v[s][w] = 0;
      m_d[s][w] = 0;
    end
    chk("req_ready", req_ready, 1);
    @(posedge clk);
    #1;
    req_valid = 0;
    last_hit = e_hit;
    chk("rsp_valid", rsp_valid, 1);
    chk("rsp_hit", rsp_hit, e_hit);
    if (e_hit) begin
      chk("rsp_way", rsp_way, hw);
      chk("rsp_dirty", rsp_dirty, e_dirty);
    end
    chk("victim_way", victim_way, vic);
    chk("victim_valid", victim_valid, e_vv);
    chk("victim_dirty", victim_dirty, e_vd);
    if (e_vv) chk("victim_tag", victim_tag, e_vt);
  endtask

  task automatic idle();
    req_valid = 0;
    @(posedge clk);
    #1;
    chk("idle_rsp_valid", rsp_valid, 0);
    chk("hold_rsp_hit", rsp_hit, last_hit);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals();
    rst_n = 1;
    wait_sweep(128);
    op(0, 9, 'h55, 0, 0);
    chk("tp_first_vic_way", victim_way, 0);
    chk("tp_first_vic_valid", victim_valid, 0);
    for (int w = 0; w < 4; w++) op(2, 5, 'h100 + w, w, 0);
    op(0, 5, 'h102, 0, 0);
    chk("tp_hit_way2", rsp_way, 2);
    op(0, 5, 'h100, 0, 0);
    op(0, 5, 'h1ff, 0, 0);
    chk("tp_lru_vic", victim_way, 1);
    chk("tp_lru_tag", victim_tag, 'h101);
    op(1, 5, 'h103, 0, 0);
    op(0, 5, 'h103, 0, 0);
    chk("tp_write_dirty", rsp_dirty, 1);
    op(0, 5, 'h101, 0, 0);
    op(0, 5, 'h100, 0, 0);
    op(0, 5, 'h102, 0, 0);
    op(0, 5, 'h1ff, 0, 0);
    chk("tp_dirty_vic", victim_dirty, 1);
    op(3, 5, 0, 2, 0);
    op(0, 5, 'h1ff, 0, 0);
    chk("tp_inval_vic", victim_way, 2);
    op(0, 5, 'h102, 0, 0);
    idle();
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 9) == 0) idle();
      else op(2'($urandom_range(0, 3)),
              ($urandom_range(0, 7) == 0) ? $urandom_range(0, 127) : $urandom_range(0, 3),
              $urandom_range(0, 5), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end
    flush = 1;
    req_valid = 1;
    req_op = 0;
    req_set = 5;
    req_tag = 'h100;
    #1;
    chk("flush_ready", req_ready, 0);
    @(posedge clk);
    #1;
    flush = 0;
    req_valid = 0;
    chk("flush_no_rsp", rsp_valid, 0);
    wait_sweep(128);
    op(0, 5, 'h100, 0, 0);
    chk("tp_flush_miss", rsp_hit, 0);
    flush = 1;
    @(posedge clk);
    #1;
    flush = 0;
    repeat (40) @(posedge clk);
    #1;
    rst_n = 0;
    #1;
    check_reset_vals();
    @(posedge clk);
    #1;
    rst_n = 1;
    wait_sweep(128);
    for (int i = 0; i < 200; i++)
      op(2'($urandom_range(0, 3)), $urandom_range(0, 2), $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    idle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/tag_directory.md
# tag_directory

Parametrised set-associative tag directory for the cache controller, successor to the fixed 128-set/4-way tag store. Adds per-way dirty bits, true-LRU replacement with victim reporting, invalidate and write-hit operations, a registered response with valid/ready request handshake, and a hardware sweep that clears all valid/dirty bits after reset and on flush. It sits between the controller FSM and the data array; the controller issues one operation per handshake and acts on the response.

## Interface

- NUM_SETS, 128, number of sets (power of two, ≥2)
- WAYS, 4, associativity (power of two, 2..16)
- TAG_BITS, 19, tag width
- SET_BITS, $clog2(NUM_SETS), set index width (derived)
- WAY_BITS, $clog2(WAYS), way index width (derived)

- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  request full invalidate sweep; sampled only in IDLE
- busy  out  1  high while sweep in progress
- req_valid  in  1  request present
- req_ready  out  1  directory can accept; = (state==IDLE) && !flush
- req_op  in  2  00 LOOKUP, 01 WRITE (lookup and set dirty on hit), 10 FILL, 11 INVAL
- req_set  in  SET_BITS  set index
- req_tag  in  TAG_BITS  tag to compare/install
- req_way  in  WAY_BITS  target way for FILL/INVAL
- req_dirty  in  1  dirty value installed by FILL
- rsp_valid  out  1  one-cycle pulse, response for the previous accepted request
- rsp_hit  out  1  tag matched a valid way (LOOKUP/WRITE); 0 for FILL/INVAL
- rsp_way  out  WAY_BITS  matching way (lowest index on multiple matches)
- rsp_dirty  out  1  dirty bit of matching way before the operation
- victim_way  out  WAY_BITS  replacement candidate for req_set
- victim_valid  out  1  candidate way currently valid
- victim_dirty  out  1  candidate way dirty (writeback required)
- victim_tag  out  TAG_BITS  candidate's stored tag

## Operation

- Storage: tag[NUM_SETS][WAYS], valid, dirty, age[WAY_BITS] per way. Only valid/dirty/age are initialised (by sweep); tags are don't-care while invalid.
- States: INIT (sweep), IDLE. Reset → INIT, sweep counter 0. INIT: each cycle set[cnt]: valid=0, dirty=0, age[w]=w; cnt increments; after cnt==NUM_SETS-1 → IDLE. IDLE & flush → INIT, cnt=0. flush during INIT ignored.
- Accept = req_valid && req_ready. Compare against all ways of req_set in the accept cycle; update arrays at that edge; register response.
- LOOKUP: hit → way becomes MRU. Miss → no state change.
- WRITE: as LOOKUP; on hit also dirty[way]=1.
- FILL: tag[req_way]=req_tag, valid=1, dirty=req_dirty, req_way becomes MRU. No duplicate-tag check.
- INVAL: valid[req_way]=0, dirty=0; ages unchanged.
- LRU touch of way w with age a: every way with age < a increments, w set to 0. Ages remain a permutation of 0..WAYS-1.
- Victim: lowest-index invalid way; if all valid, way with age WAYS-1. Victim fields computed from the pre-update state of the accepted request's set, registered with the response.
- All ops on a set in back-to-back cycles see the effect of the previous op.

## Timing

- Reset values: busy=1, req_ready=0, rsp_valid=0, rsp_hit=0, rsp_way=0, rsp_dirty=0, victim_way=0, victim_valid=0, victim_dirty=0, victim_tag=0, state=INIT.
- Sweep: busy high exactly NUM_SETS cycles after rst_n release or flush acceptance; req_ready rises the cycle busy falls.
- Latency: request accepted at edge N → rsp_valid high for the cycle following edge N, one response per request, throughput 1/cycle.
- flush and req_valid in same IDLE cycle: flush wins, request not accepted (req_ready=0), retried by controller.
- rsp_* hold last values when rsp_valid=0; only rsp_valid is a pulse.
- rst_n asserted mid-sweep or mid-response: immediate return to reset values, sweep restarts from set 0.

## Test plan

- Reset release, NUM_SETS=128 → busy high 128 cycles, req_ready=0 throughout, then 1; LOOKUP any set → rsp_hit=0, victim_way=0, victim_valid=0.
- FILL set 5 ways 0..3 tags 0x100..0x103 dirty=0, LOOKUP tag 0x102 → rsp_valid next cycle, rsp_hit=1, rsp_way=2, rsp_dirty=0.
- After above, LOOKUP 0x100 then LOOKUP set 5 miss → victim_way=1 (LRU), victim_valid=1, victim_tag=0x101.
- WRITE tag 0x103 set 5, then LOOKUP 0x103 → first rsp_dirty=0, second rsp_dirty=1; victim selected as way 3 later reports victim_dirty=1.
- INVAL set 5 way 2, LOOKUP miss → victim_way=2, victim_valid=0; LOOKUP 0x102 → rsp_hit=0.
- flush with simultaneous req_valid in IDLE → request not accepted, busy 128 cycles; afterwards LOOKUP 0x100 set 5 → rsp_hit=0; rst_n pulse mid-sweep → sweep restarts, busy 128 further cycles.
